// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the Nios II OCI RAM arbiter.
// The optional debugack gate is enabled with the OCIMEM_DEBUGACK_GATE_EN macro.
package nios2_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_CAPT  = 2'd2
    } state_e;

    typedef enum logic {
        JOP_RD = 1'b0,
        JOP_WR = 1'b1
    } jop_e;

    typedef enum logic {
        OWN_AV = 1'b0,
        OWN_JT = 1'b1
    } owner_e;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 2;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;

endpackage

// File: rtl/nios2_ocimem_jtag_cmd_buf.sv
// JTAG side of the OCI RAM arbiter: address counter, 1-entry pending command
// buffer and sticky overrun flag.
module nios2_ocimem_jtag_cmd_buf
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              release_i,
    output logic              pend_valid_o,
    output jop_e              pend_op_o,
    output logic [ADDR_W-1:0] pend_addr_o,
    output logic [31:0]       pend_data_o,
    output logic              overrun_o
);

    logic              pend_valid_q, pend_valid_d;
    jop_e              pend_op_q, pend_op_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
    logic              overrun_q, overrun_d;
    logic              cmd_new;
    logic              accept;
    logic              unused_jdo;

    assign unused_jdo = ^jdo;
    assign cmd_new    = take_action_ocimem_b | take_no_action_ocimem_a;
    // A release in the same cycle frees the slot for the incoming command.
    assign accept     = cmd_new & (~pend_valid_q | release_i);

    always_comb begin
        jtag_addr_d  = jtag_addr_q;
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        overrun_d    = overrun_q | (cmd_new & pend_valid_q & ~release_i);

        if (take_action_ocimem_a) begin
            jtag_addr_d = jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
        end else if (release_i) begin
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        end

        if (release_i) begin
            pend_valid_d = 1'b0;
        end
        // The captured address is the counter value once this cycle's update lands.
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_op_d    = take_action_ocimem_b ? JOP_WR : JOP_RD;
            pend_addr_d  = jtag_addr_d;
            pend_data_d  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= JOP_RD;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            jtag_addr_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            jtag_addr_q  <= jtag_addr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_op_o    = pend_op_q;
    assign pend_addr_o  = pend_addr_q;
    assign pend_data_o  = pend_data_q;
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between Avalon and JTAG.
// Define OCIMEM_DEBUGACK_GATE_EN to add the debugack input gating JTAG commands.
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    output logic              av_readdatavalid,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
`ifdef OCIMEM_DEBUGACK_GATE_EN
    input  logic              debugack,
`endif
    output logic [31:0]       MonDReg,
    output logic              jtag_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [1:0]        dbg_state_o
);

    state_e            state_q, state_d;
    owner_e            rd_owner_q;
    logic              rr_jt_q;
    logic              av_req, jt_cand, grant_av, grant_jt;
    logic              pend_valid;
    jop_e              pend_op;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wren_q;
    logic [3:0]        ram_be_q;
    logic [31:0]       ram_wdata_q;
    logic [31:0]       av_rdata_q;
    logic              av_rdv_q;
    logic [31:0]       mon_q;

    nios2_ocimem_jtag_cmd_buf #(.ADDR_W(ADDR_W)) u_cmd_buf (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .release_i               (grant_jt),
        .pend_valid_o            (pend_valid),
        .pend_op_o               (pend_op),
        .pend_addr_o             (pend_addr),
        .pend_data_o             (pend_data),
        .overrun_o               (jtag_overrun)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((grant_av & av_read) | (grant_jt & (pend_op == JOP_RD))) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_CAPT;
            ST_RD_CAPT:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // rr_jt_q set means JTAG wins the next contested cycle.
    always_comb begin
        av_req = av_read | av_write;
`ifdef OCIMEM_DEBUGACK_GATE_EN
        jt_cand = pend_valid & debugack;
`else
        jt_cand = pend_valid;
`endif
        grant_av = 1'b0;
        grant_jt = 1'b0;
        if (state_q == ST_IDLE) begin
            if (av_req && (!jt_cand || !rr_jt_q)) begin
                grant_av = 1'b1;
            end else if (jt_cand) begin
                grant_jt = 1'b1;
            end
        end
        av_waitrequest = ~reset_n | (av_req & ~grant_av);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_addr_q  <= '0;
            ram_wren_q  <= 1'b0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            av_rdata_q  <= '0;
            av_rdv_q    <= 1'b0;
            mon_q       <= '0;
            rd_owner_q  <= OWN_AV;
            rr_jt_q     <= RR_INIT;
        end else begin
            ram_wren_q <= 1'b0;
            av_rdv_q   <= 1'b0;
            if (grant_av) begin
                ram_addr_q  <= av_address;
                ram_wren_q  <= av_write;
                ram_be_q    <= av_byteenable;
                ram_wdata_q <= av_writedata;
                rd_owner_q  <= OWN_AV;
            end else if (grant_jt) begin
                ram_addr_q  <= pend_addr;
                ram_wren_q  <= (pend_op == JOP_WR);
                ram_be_q    <= 4'hF;
                ram_wdata_q <= pend_data;
                rd_owner_q  <= OWN_JT;
            end
            if ((state_q == ST_IDLE) && av_req && jt_cand) begin
                rr_jt_q <= grant_av;
            end
            if (state_q == ST_RD_CAPT) begin
                if (rd_owner_q == OWN_AV) begin
                    av_rdata_q <= ram_rdata;
                    av_rdv_q   <= 1'b1;
                end else begin
                    mon_q <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr         = ram_addr_q;
    assign ram_wren         = ram_wren_q;
    assign ram_byteenable   = ram_be_q;
    assign ram_wdata        = ram_wdata_q;
    assign av_readdata      = av_rdata_q;
    assign av_readdatavalid = av_rdv_q;
    assign MonDReg          = mon_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter with a behavioural RAM and
// reference memory/address model.
module tb_nios2_ocimem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] av_address;
    logic              av_read, av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic              av_waitrequest;
    logic [31:0]       av_readdata;
    logic              av_readdatavalid;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic              debugack;
    logic [31:0]       MonDReg;
    logic              jtag_overrun;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [1:0]        dbg_state;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          ref_jaddr;
    int          n_tests;
    int          n_fail;

    nios2_ocimem_arbiter #(.ADDR_W(ADDR_W), .RR_INIT(1'b0)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_waitrequest          (av_waitrequest),
        .av_readdata             (av_readdata),
        .av_readdatavalid        (av_readdatavalid),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
`ifdef OCIMEM_DEBUGACK_GATE_EN
        .debugack                (debugack),
`endif
        .MonDReg                 (MonDReg),
        .jtag_overrun            (jtag_overrun),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .dbg_state_o             (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteenable[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic wait_accept(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!av_waitrequest) ok = 1'b1;
            else tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: waitrequest still 1 after 20 cycles, required 0", name);
        end
    endtask

    task automatic av_read_txn(input logic [ADDR_W-1:0] addr);
        bit          ok;
        bit          early;
        logic [31:0] exp;
        exp        = ref_mem[addr];
        av_address = addr;
        av_read    = 1'b1;
        wait_accept("av_read_accept", ok);
        tick();
        av_read = 1'b0;
        early   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3 && av_readdatavalid) early = 1'b1;
        end
        n_tests++;
        if (early || av_readdatavalid !== 1'b1 || av_readdata !== exp) begin
            n_fail++;
            $display("FAIL av_read@%h: early=%0d valid=%b data=%h, required valid at N+3 data=%h",
                     addr, early, av_readdatavalid, av_readdata, exp);
        end
        tick();
    endtask

    task automatic av_write_txn(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                                input logic [3:0] be);
        bit ok;
        av_address    = addr;
        av_writedata  = data;
        av_byteenable = be;
        av_write      = 1'b1;
        wait_accept("av_write_accept", ok);
        tick();
        av_write      = 1'b0;
        ref_mem[addr] = merge(ref_mem[addr], data, be);
    endtask

    task automatic jt_load(input logic [ADDR_W-1:0] addr);
        jdo                  = '0;
        jdo[ADDR_W+1:2]      = addr;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        ref_jaddr            = int'(addr);
    endtask

    task automatic jt_write(input logic [31:0] data);
        jdo                  = {3'b000, data, 3'b000};
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        ref_mem[ref_jaddr]   = data;
        ref_jaddr            = (ref_jaddr + 1) % DEPTH;
        tick();
        tick();
    endtask

    task automatic jt_read_check(input string name);
        logic [31:0] exp;
        exp                     = ref_mem[ref_jaddr];
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (MonDReg !== exp) begin
            n_fail++;
            $display("FAIL %s@%0h: MonDReg=%h, required %h", name, ref_jaddr, MonDReg, exp);
        end
        ref_jaddr = (ref_jaddr + 1) % DEPTH;
    endtask

    task automatic test_reset();
        av_read = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (av_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_waitreq: got %b, required 1", av_waitrequest);
        end
        n_tests++;
        if ({ram_addr, ram_wren, ram_byteenable, ram_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_ram: addr=%h wren=%b be=%h wdata=%h, required all 0",
                     ram_addr, ram_wren, ram_byteenable, ram_wdata);
        end
        n_tests++;
        if ({av_readdata, av_readdatavalid, MonDReg, jtag_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: rdata=%h rdv=%b mon=%h ovr=%b, required all 0",
                     av_readdata, av_readdatavalid, MonDReg, jtag_overrun);
        end
        av_read = 1'b0;
        tick();
        reset_n   = 1'b1;
        ref_jaddr = 0;
        tick();
    endtask

    task automatic test_avalon_read();
        av_read_txn(8'h10);
        av_read_txn(8'h11);
    endtask

    task automatic test_jtag_wrap();
        jt_load(8'hFF);
        jdo                  = {3'b000, 32'h0000_0011, 3'b000};
        take_action_ocimem_b = 1'b1;
        tick();
        jdo                  = {3'b000, 32'h0000_0022, 3'b000};
        tick();
        take_action_ocimem_b = 1'b0;
        repeat (3) tick();
        ref_mem[255] = 32'h11;
        ref_mem[0]   = 32'h22;
        ref_jaddr    = 1;
        @(negedge clk);
        n_tests++;
        if (mem[255] !== 32'h11 || mem[0] !== 32'h22 || jtag_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL jtag_wrap: ram[ff]=%h ram[0]=%h ovr=%b, required 11 22 0",
                     mem[255], mem[0], jtag_overrun);
        end
        jt_read_check("jtag_wrap_next");
    endtask

    task automatic rr_pair(input bit jt_first, input logic [ADDR_W-1:0] av_a,
                           input logic [31:0] av_d, input logic [31:0] jt_d);
        logic [ADDR_W-1:0] jt_a;
        jt_a                 = ADDR_W'(ref_jaddr);
        jdo                  = {3'b000, jt_d, 3'b000};
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        av_address           = av_a;
        av_writedata         = av_d;
        av_byteenable        = 4'hF;
        av_write             = 1'b1;
        @(negedge clk);
        n_tests++;
        if (av_waitrequest !== jt_first) begin
            n_fail++;
            $display("FAIL rr_first_waitreq: got %b, required %b", av_waitrequest, jt_first);
        end
        if (jt_first) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (ram_wren !== 1'b1 || ram_addr !== jt_a || ram_wdata !== jt_d || av_waitrequest !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_jt_first: wren=%b addr=%h wdata=%h wait=%b, required 1 %h %h 0",
                         ram_wren, ram_addr, ram_wdata, av_waitrequest, jt_a, jt_d);
            end
            tick();
            av_write = 1'b0;
            @(negedge clk);
            n_tests++;
            if (ram_wren !== 1'b1 || ram_addr !== av_a || ram_wdata !== av_d) begin
                n_fail++;
                $display("FAIL rr_av_second: wren=%b addr=%h wdata=%h, required 1 %h %h",
                         ram_wren, ram_addr, ram_wdata, av_a, av_d);
            end
        end else begin
            tick();
            av_write = 1'b0;
            @(negedge clk);
            n_tests++;
            if (ram_wren !== 1'b1 || ram_addr !== av_a || ram_wdata !== av_d) begin
                n_fail++;
                $display("FAIL rr_av_first: wren=%b addr=%h wdata=%h, required 1 %h %h",
                         ram_wren, ram_addr, ram_wdata, av_a, av_d);
            end
            tick();
            @(negedge clk);
            n_tests++;
            if (ram_wren !== 1'b1 || ram_addr !== jt_a || ram_wdata !== jt_d) begin
                n_fail++;
                $display("FAIL rr_jt_second: wren=%b addr=%h wdata=%h, required 1 %h %h",
                         ram_wren, ram_addr, ram_wdata, jt_a, jt_d);
            end
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_wren_pulse: got %b, required 0", ram_wren);
        end
        ref_mem[av_a] = av_d;
        ref_mem[jt_a] = jt_d;
        ref_jaddr     = (ref_jaddr + 1) % DEPTH;
        tick();
    endtask

    task automatic test_round_robin();
        jt_load(8'h40);
        rr_pair(1'b0, 8'h80, $urandom, $urandom);
        rr_pair(1'b1, 8'h81, $urandom, $urandom);
        rr_pair(1'b0, 8'h82, $urandom, $urandom);
        av_read_txn(8'h80);
        av_read_txn(8'h42);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        av_byteenable = 4'hF;
        av_write      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a            = ADDR_W'(8'hA0 + i);
            d            = $urandom;
            av_address   = a;
            av_writedata = d;
            ref_mem[a]   = d;
            @(negedge clk);
            n_tests++;
            if (av_waitrequest !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_waitreq[%0d]: got %b, required 0", i, av_waitrequest);
            end
            tick();
        end
        av_write = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) av_read_txn(ADDR_W'(8'hA0 + i));
    endtask

    task automatic test_overrun();
        bit          ok;
        int          j0;
        logic [31:0] exp_av;
        j0         = ref_jaddr;
        exp_av     = ref_mem[8'h10];
        av_address = 8'h10;
        av_read    = 1'b1;
        wait_accept("ovr_av_accept", ok);
        tick();
        av_read                 = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        tick();
        tick();
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        n_tests++;
        if (av_readdatavalid !== 1'b1 || av_readdata !== exp_av || jtag_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: rdv=%b rdata=%h ovr=%b, required 1 %h 1",
                     av_readdatavalid, av_readdata, jtag_overrun, exp_av);
        end
        repeat (4) tick();
        @(negedge clk);
        n_tests++;
        if (MonDReg !== ref_mem[j0] || jtag_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_first_read: mon=%h ovr=%b, required %h 1",
                     MonDReg, jtag_overrun, ref_mem[j0]);
        end
        ref_jaddr = (j0 + 1) % DEPTH;
        tick();
        jt_read_check("overrun_dropped");
        @(negedge clk);
        n_tests++;
        if (jtag_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b, required 1", jtag_overrun);
        end
        tick();
    endtask

    task automatic test_reset_in_read();
        bit rdv_seen;
        ref_mem[8'h33] = 32'h1234_5678;
        mem[8'h33]     = 32'h1234_5678;
        av_address     = 8'h33;
        av_read        = 1'b1;
        @(negedge clk);
        n_tests++;
        if (av_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rd_accept: waitreq=%b, required 0", av_waitrequest);
        end
        tick();
        av_read = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (av_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rd_waitreq: got %b, required 1", av_waitrequest);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ram_addr, ram_wren, ram_byteenable, ram_wdata, MonDReg, jtag_overrun, av_readdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_rd_zero: addr=%h wren=%b be=%h wd=%h mon=%h ovr=%b rd=%h, required all 0",
                     ram_addr, ram_wren, ram_byteenable, ram_wdata, MonDReg, jtag_overrun, av_readdata);
        end
        rdv_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (av_readdatavalid) rdv_seen = 1'b1;
        end
        n_tests++;
        if (rdv_seen) begin
            n_fail++;
            $display("FAIL rst_rd_novalid: readdatavalid seen=1, required 0");
        end
        ref_jaddr = 0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: av_read_txn(ADDR_W'($urandom));
                1: av_write_txn(ADDR_W'($urandom), $urandom, 4'($urandom_range(1, 15)));
                2: jt_load(ADDR_W'($urandom));
                3: jt_write($urandom);
                default: jt_read_check("rand_jt_read");
            endcase
        end
        for (int i = 0; i < 8; i++) av_read_txn(ADDR_W'($urandom));
    endtask

`ifdef OCIMEM_DEBUGACK_GATE_EN
    task automatic test_debugack();
        logic [31:0] before;
        logic [31:0] exp;
        jt_load(8'h5A);
        ref_mem[8'h5A] = ~MonDReg;
        mem[8'h5A]     = ~MonDReg;
        before         = MonDReg;
        exp            = ref_mem[8'h5A];
        debugack       = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        n_tests++;
        if (MonDReg !== before) begin
            n_fail++;
            $display("FAIL dbgack_hold: mon=%h, required %h", MonDReg, before);
        end
        tick();
        debugack = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (MonDReg !== exp) begin
            n_fail++;
            $display("FAIL dbgack_release: mon=%h, required %h", MonDReg, exp);
        end
        ref_jaddr = 8'h5B;
        tick();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        av_address = '0;
        av_read = 1'b0;
        av_write = 1'b0;
        av_writedata = '0;
        av_byteenable = 4'hF;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        debugack = 1'b1;
        ref_jaddr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        ref_mem[8'h10] = 32'hCAFE_F00D;
        mem[8'h10]     = 32'hCAFE_F00D;

        test_reset();
        test_avalon_read();
        test_jtag_wrap();
        test_round_robin();
        test_back_to_back();
        test_overrun();
        test_reset_in_read();
        test_random();
`ifdef OCIMEM_DEBUGACK_GATE_EN
        test_debugack();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
